// File: rtl/sccb_cfg_sequencer.sv
// Schedules SCCB register writes: boot table from ROM first, then runtime requests.
// One 3-phase write in flight at a time, with a settle gap after each and a completion timeout.
module sccb_cfg_sequencer #(
  parameter int unsigned ROM_DEPTH      = 75,
  parameter int unsigned GAP_CYCLES     = 25000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter bit          AUTO_INIT      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        rt_req,
  input  logic [7:0]  rt_addr,
  input  logic [7:0]  rt_data,
  output logic        rt_ack,
  output logic        m_start,
  output logic [7:0]  m_id,
  output logic [7:0]  m_reg,
  output logic [7:0]  m_data,
  input  logic        m_busy,
  input  logic        m_done,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, GAP} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next, idx_inc, addr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       reg_next, data_next;
  logic             init_pend, init_pend_next;
  logic             restart, restart_next;
  logic             init_active, active_next;
  logic             done_next, err_next;
  logic             is_rt, is_rt_next;

  assign idx_inc = idx + IDX_W'(1);
  assign m_id    = DEV_ID;
  assign busy    = (state != IDLE);
  // Start fires in the very cycle the master reports idle, so it follows m_busy directly.
  assign m_start = (state == ISSUE) && !m_busy;
  assign rt_ack  = m_start && is_rt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      rom_addr    <= '0;
      cnt         <= '0;
      m_reg       <= '0;
      m_data      <= '0;
      init_pend   <= AUTO_INIT;
      restart     <= 1'b0;
      init_active <= 1'b0;
      init_done   <= 1'b0;
      err         <= 1'b0;
      is_rt       <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      rom_addr    <= addr_next;
      cnt         <= cnt_next;
      m_reg       <= reg_next;
      m_data      <= data_next;
      init_pend   <= init_pend_next;
      restart     <= restart_next;
      init_active <= active_next;
      init_done   <= done_next;
      err         <= err_next;
      is_rt       <= is_rt_next;
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    addr_next      = rom_addr;
    cnt_next       = cnt;
    reg_next       = m_reg;
    data_next      = m_data;
    init_pend_next = init_pend;
    restart_next   = restart;
    active_next    = init_active;
    done_next      = init_done;
    err_next       = err;
    is_rt_next     = is_rt;

    case (state)
      IDLE: begin
        if (init_pend || init_start || restart) begin
          state_next     = FETCH;
          idx_next       = '0;
          addr_next      = '0;
          init_pend_next = 1'b0;
          restart_next   = 1'b0;
          active_next    = 1'b1;
          done_next      = 1'b0;
        end else if (init_done && rt_req) begin
          state_next = ISSUE;
          reg_next   = rt_addr;
          data_next  = rt_data;
          is_rt_next = 1'b1;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        if (restart) begin
          state_next   = FETCH;
          restart_next = 1'b0;
          idx_next     = '0;
          addr_next    = '0;
        end else if (rom_data == 16'hFFFF || idx == IDX_W'(ROM_DEPTH)) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          active_next = 1'b0;
        end else begin
          state_next = ISSUE;
          reg_next   = rom_data[15:8];
          data_next  = rom_data[7:0];
          is_rt_next = 1'b0;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        // Done wins over a timeout expiring in the same cycle.
        if (m_done) begin
          state_next = GAP;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = GAP;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_next = '0;
          if (restart) begin
            state_next   = FETCH;
            restart_next = 1'b0;
            idx_next     = '0;
            addr_next    = '0;
            active_next  = 1'b1;
          end else if (init_active) begin
            state_next = FETCH;
            idx_next   = idx_inc;
            // Past the last entry the address holds; LATCH ends the load on the index.
            if (idx_inc < IDX_W'(ROM_DEPTH)) addr_next = idx_inc;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (init_start) begin
      done_next = 1'b0;
      err_next  = 1'b0;
      if (state != IDLE) restart_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: ROM model, SCCB master model, start/done monitor.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

  localparam int unsigned ROM_DEPTH = 75;
  localparam int unsigned GAP       = 10;
  localparam int unsigned TMO       = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        rt_req = 1'b0;
  logic [7:0]  rt_addr = 8'h00;
  logic [7:0]  rt_data = 8'h00;
  logic        rt_ack, m_start;
  logic [7:0]  m_id, m_reg, m_data;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        init_done, busy, err;

  logic [15:0] rom [0:255];
  int          cyc = 0;
  int          lat = 20;
  int          mcnt = 0;
  logic [7:0]  hang_reg = 8'hEE;
  int          errors = 0;
  int          checks = 0;
  int          ack_cnt = 0;
  logic [7:0]  max_addr = 8'h00;
  int          st_cyc[$];
  int          dn_cyc[$];
  logic [7:0]  st_reg[$];
  logic [7:0]  st_dat[$];

  sccb_cfg_sequencer #(
    .ROM_DEPTH(ROM_DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
    .DEV_ID(8'h42), .AUTO_INIT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rt_req(rt_req), .rt_addr(rt_addr), .rt_data(rt_data), .rt_ack(rt_ack),
    .m_start(m_start), .m_id(m_id), .m_reg(m_reg), .m_data(m_data),
    .m_busy(m_busy), .m_done(m_done),
    .init_done(init_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Master: m_done pulses lat cycles after m_start, never for the write to hang_reg.
  always @(posedge clk) begin
    if (m_start && m_reg != hang_reg) mcnt <= lat - 1;
    else if (mcnt != 0)               mcnt <= mcnt - 1;
    m_done <= (mcnt == 1);
  end

  always @(negedge clk) begin
    if (m_start) begin
      st_cyc.push_back(cyc);
      st_reg.push_back(m_reg);
      st_dat.push_back(m_data);
    end
    if (m_done) dn_cyc.push_back(cyc);
    if (rt_ack) ack_cnt = ack_cnt + 1;
    if (rom_addr > max_addr) max_addr = rom_addr;
  end

  function automatic logic [15:0] ent(input int i);
    logic [7:0] a, d;
    case (i)
      0: return 16'h3A04;
      1: return 16'h1100;
      2: return 16'h6B4A;
      default: begin
        a = 8'(8'h20 + i);
        d = 8'(i * 3);
        return {a, d};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_init(output int n);
    init_start = 1'b1;
    n = cyc;
    step();
    init_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!init_done && k < budget) begin step(); k++; end
    chk(tag, 32'(init_done), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int k = 0;
    while (st_cyc.size() < target && k < budget) begin step(); k++; end
    chk(tag, 32'(st_cyc.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int k = 0;
    while (!rt_ack && k < budget) begin step(); k++; end
    chk(tag, 32'(rt_ack), 32'd1);
  endtask

  initial begin
    int n, s, b, d, a, r, bad;
    for (int i = 0; i < 256; i++) rom[i] = ent(i);
    rom[3] = 16'hFFFF;

    // Reset values
    repeat (3) step();
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_m_start", 32'(m_start), 32'h0);
    chk("rst_rt_ack", 32'(rt_ack), 32'h0);
    chk("rst_m_reg", 32'(m_reg), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_m_id", 32'(m_id), 32'h42);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // Auto-init: three entries then the marker
    reset = 1'b0;
    wait_done(300, "auto_init_done");
    chk("auto_count", 32'(st_cyc.size()), 32'd3);
    chk("auto_reg0", 32'(st_reg[0]), 32'h3A);
    chk("auto_dat0", 32'(st_dat[0]), 32'h04);
    chk("auto_reg1", 32'(st_reg[1]), 32'h11);
    chk("auto_dat1", 32'(st_dat[1]), 32'h00);
    chk("auto_reg2", 32'(st_reg[2]), 32'h6B);
    chk("auto_dat2", 32'(st_dat[2]), 32'h4A);
    chk("auto_m_id", 32'(m_id), 32'h42);
    chk("auto_busy", 32'(busy), 32'h0);
    chk("auto_spacing", 32'(st_cyc[1] - dn_cyc[0]), 32'(GAP + 3));

    // Priority: runtime request raised during the load waits for init_done
    b = st_cyc.size();
    a = ack_cnt;
    pulse_init(n);
    chk("init_done_clear", 32'(init_done), 32'h0);
    chk("init_busy", 32'(busy), 32'h1);
    repeat (4) step();
    rt_addr = 8'h12;
    rt_data = 8'h80;
    rt_req  = 1'b1;
    wait_done(300, "prio_init_done");
    r = cyc;
    chk("prio_no_early_ack", 32'(ack_cnt - a), 32'd0);
    chk("prio_table_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("init_latency", 32'(st_cyc[b] - n), 32'd3);
    wait_ack(20, "prio_ack_seen");
    chk("rt_latency", 32'(cyc - r), 32'd1);
    chk("rt_m_start", 32'(m_start), 32'h1);
    chk("rt_m_reg", 32'(m_reg), 32'h12);
    chk("rt_m_data", 32'(m_data), 32'h80);
    rt_req = 1'b0;
    wait_idle(100, "rt_idle");
    chk("rt_single_start", 32'(st_cyc.size() - b), 32'd4);
    chk("rt_single_ack", 32'(ack_cnt - a), 32'd1);

    // Timeout on entry 1; entry 2 still issued
    hang_reg = 8'h11;
    b = st_cyc.size();
    pulse_init(n);
    wait_starts(b + 2, 200, "tmo_issue");
    s = st_cyc[b + 1];
    while (cyc < s + int'(TMO)) step();
    chk("tmo_err_before", 32'(err), 32'h0);
    step();
    chk("tmo_err_set", 32'(err), 32'h1);
    wait_done(300, "tmo_init_done");
    chk("tmo_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("tmo_next_reg", 32'(st_reg[b + 2]), 32'h6B);
    chk("tmo_next_time", 32'(st_cyc[b + 2] - s), 32'(TMO + GAP + 3));
    chk("tmo_err_sticky", 32'(err), 32'h1);
    hang_reg = 8'hEE;

    // Done arriving on the exact expiry cycle is not an error
    lat = int'(TMO);
    b = st_cyc.size();
    pulse_init(n);
    chk("err_cleared_by_init", 32'(err), 32'h0);
    wait_done(400, "edge_init_done");
    chk("edge_starts", 32'(st_cyc.size() - b), 32'd3);
    chk("edge_no_err", 32'(err), 32'h0);
    lat = 20;

    // Restart during entry 5, then a full 75-entry table with no marker
    rom[3] = ent(3);
    b = st_cyc.size();
    d = dn_cyc.size();
    pulse_init(n);
    wait_starts(b + 6, 400, "rst_entry5");
    s = st_cyc[b + 5];
    repeat (5) step();
    pulse_init(n);
    wait_starts(b + 7, 100, "rst_reissue");
    chk("rst_restart_time", 32'(st_cyc[b + 6] - s), 32'(20 + GAP + 3));
    chk("rst_entry0_reg", 32'(st_reg[b + 6]), 32'h3A);
    chk("rst_entry0_dat", 32'(st_dat[b + 6]), 32'h04);
    wait_done(3500, "full_init_done");
    chk("full_count", 32'(st_cyc.size() - b), 32'd81);
    bad = 0;
    for (int k = 0; k < 75; k++) begin
      if ({st_reg[b + 6 + k], st_dat[b + 6 + k]} !== ent(k)) bad++;
    end
    chk("full_operands", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (st_cyc[b + k + 1] - dn_cyc[d + k] != int'(GAP + 3)) bad++;
    end
    chk("full_spacing", 32'(bad), 32'd0);
    chk("full_max_addr", 32'(max_addr), 32'd74);
    chk("full_busy", 32'(busy), 32'h0);

    // Busy hold in ISSUE: no start, operands steady, start on first idle cycle
    b = st_cyc.size();
    a = ack_cnt;
    m_busy  = 1'b1;
    rt_addr = 8'h55;
    rt_data = 8'hC3;
    rt_req  = 1'b1;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (m_start !== 1'b0 || m_reg !== 8'h55 || m_data !== 8'hC3 || busy !== 1'b1) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    m_busy = 1'b0;
    step();
    chk("hold_m_start", 32'(m_start), 32'h1);
    chk("hold_rt_ack", 32'(rt_ack), 32'h1);
    chk("hold_m_reg", 32'(m_reg), 32'h55);
    chk("hold_m_data", 32'(m_data), 32'hC3);
    rt_req = 1'b0;
    step();
    chk("hold_wait_reg", 32'(m_reg), 32'h55);
    wait_idle(100, "hold_idle");
    chk("hold_single_start", 32'(st_cyc.size() - b), 32'd1);
    chk("hold_single_ack", 32'(ack_cnt - a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
